// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   UART transmitter for the sim UART master. It takes bytes from an upstream
//   FIFO through that FIFO's empty/pop interface and sends each byte on o_tx
//   as one start bit, DW data bits (LSB first) and STOP_BITS stop bits.
//
// Ports
//   i_clk    : clock
//   i_reset  : synchronous, active-high reset
//   i_dat    : FIFO head data; sampled only in the LATCH cycle
//   i_empty  : FIFO empty flag; looked at only in IDLE
//   o_pop    : one-cycle pop strobe to the FIFO (high only in LATCH)
//   o_tx     : serial line, registered, idles high
//   o_busy   : registered; high from the fetch until the line has been
//              idle for one cycle after the last stop bit
//
// FSM states
//   state | meaning
//   IDLE  | line at mark, waiting for the FIFO to be non-empty
//   LATCH | one cycle: capture the FIFO head, pop it
//   START | start bit (line low) for CLK_DIV cycles
//   DATA  | DW data bits, LSB first, CLK_DIV cycles each
//   STOP  | stop bit(s), line high for STOP_BITS*CLK_DIV cycles
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLK_DIV   = 217,
    parameter int DW        = 8,
    parameter int STOP_BITS = 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [DW-1:0] i_dat,
    input  logic          i_empty,
    output logic          o_pop,
    output logic          o_tx,
    output logic          o_busy
);

    localparam int BW = $clog2(CLK_DIV);
    localparam int CW = $clog2(DW + 1);

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DW - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [BW-1:0] baud_cnt;
    logic [CW-1:0] bit_cnt;
    logic [DW-1:0] shift_reg;
    logic [DW-1:0] shift_nxt;
    logic          tx_nxt;
    logic          busy_nxt;
    logic          baud_done;

    assign baud_done = (baud_cnt == BAUD_LAST);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!i_empty) begin
                    state_nxt = LATCH;
                end
            end
            LATCH: begin
                state_nxt = START;
            end
            START: begin
                if (baud_done) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (baud_done && (bit_cnt == DATA_LAST)) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (baud_done && (bit_cnt == STOP_LAST)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output logic. o_tx and o_busy are computed one cycle ahead from the
    // next state so that their flops change on the same edge as the state.
    always_comb begin
        o_pop     = (state == LATCH);
        shift_nxt = shift_reg;
        tx_nxt    = 1'b1;
        if (state == LATCH) begin
            shift_nxt = i_dat;
        end else if ((state == DATA) && baud_done) begin
            shift_nxt = shift_reg >> 1;
        end
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
        // Holding busy through the first IDLE cycle keeps it high across the
        // IDLE/LATCH gap of back-to-back frames.
        busy_nxt = (state_nxt != IDLE) || (state != IDLE);
    end

    // Datapath: registered outputs, shift register, baud and bit counters
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_tx      <= 1'b1;
            o_busy    <= 1'b0;
            shift_reg <= '0;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
        end else begin
            o_tx      <= tx_nxt;
            o_busy    <= busy_nxt;
            shift_reg <= shift_nxt;
            if (state_nxt != state) begin
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end else if ((state == START) || (state == DATA) || (state == STOP)) begin
                if (baud_done) begin
                    baud_cnt <= '0;
                    bit_cnt  <= bit_cnt + CW'(1);
                end else begin
                    baud_cnt <= baud_cnt + BW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo. dut1 (1 stop bit) is fed by a small
//   4-deep FIFO model with registered head/empty; dut2 (2 stop bits) is
//   driven directly. A line decoder watches dut1's o_tx.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [7:0] dat1   = 8'h00;
    logic       empty1 = 1'b1;
    logic       pop1;
    logic       tx1;
    logic       busy1;

    logic [7:0] dat2   = 8'h00;
    logic       empty2 = 1'b1;
    logic       pop2;
    logic       tx2;
    logic       busy2;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_DIV(4), .DW(8), .STOP_BITS(1)) dut1 (
        .i_clk   (clk),
        .i_reset (rst),
        .i_dat   (dat1),
        .i_empty (empty1),
        .o_pop   (pop1),
        .o_tx    (tx1),
        .o_busy  (busy1)
    );

    uart_tx_fifo #(.CLK_DIV(4), .DW(8), .STOP_BITS(2)) dut2 (
        .i_clk   (clk),
        .i_reset (rst),
        .i_dat   (dat2),
        .i_empty (empty2),
        .o_pop   (pop2),
        .o_tx    (tx2),
        .o_busy  (busy2)
    );

    // FIFO model feeding dut1: head data and empty flag are registered.
    logic [7:0] fifo_q[$];
    logic       push_req = 1'b0;
    logic [7:0] push_dat = 8'h00;
    logic       ovf      = 1'b0;

    always @(posedge clk) begin
        if (pop1 && (fifo_q.size() > 0)) fifo_q.delete(0);
        if (push_req) begin
            if (fifo_q.size() < 4) fifo_q.push_back(push_dat);
            else ovf <= 1'b1;
        end
        empty1 <= (fifo_q.size() == 0);
        dat1   <= (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end

    // Line decoder and event counters for dut1
    logic       mon_clear   = 1'b0;
    logic [7:0] rx_q[$];
    int         gap_q[$];
    logic       m_active    = 1'b0;
    logic       m_have_prev = 1'b0;
    int         m_k         = 0;
    int         m_idle      = 0;
    logic [7:0] m_byte      = 8'h00;
    int         pop_cnt     = 0;
    int         busy_cnt    = 0;
    int         pop_empty   = 0;
    int         frame_err   = 0;

    always @(negedge clk) begin
        if (mon_clear) begin
            rx_q.delete();
            gap_q.delete();
            m_active    <= 1'b0;
            m_have_prev <= 1'b0;
            m_k         <= 0;
            m_idle      <= 0;
            pop_cnt     <= 0;
            busy_cnt    <= 0;
            pop_empty   <= 0;
            frame_err   <= 0;
        end else begin
            if (pop1) pop_cnt <= pop_cnt + 1;
            if (busy1) busy_cnt <= busy_cnt + 1;
            if (pop1 && empty1) pop_empty <= pop_empty + 1;
            if (!m_active) begin
                if (tx1 == 1'b0) begin
                    m_active <= 1'b1;
                    m_k      <= 1;
                    if (m_have_prev) gap_q.push_back(m_idle);
                end else begin
                    m_idle <= m_idle + 1;
                end
            end else begin
                if ((m_k == 2) && (tx1 !== 1'b0)) frame_err <= frame_err + 1;
                if ((m_k == 38) && (tx1 !== 1'b1)) frame_err <= frame_err + 1;
                if ((m_k >= 6) && (m_k <= 34) && ((m_k % 4) == 2)) m_byte <= {tx1, m_byte[7:1]};
                if (m_k == 39) begin
                    m_active    <= 1'b0;
                    rx_q.push_back(m_byte);
                    m_idle      <= 0;
                    m_have_prev <= 1'b1;
                end
                m_k <= m_k + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        push_dat = b;
        push_req = 1'b1;
        step(1);
        push_req = 1'b0;
    endtask

    task automatic clear_mon();
        mon_clear = 1'b1;
        step(1);
        mon_clear = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int i;
        i = 0;
        while ((rx_q.size() < n) && (i < budget)) begin
            step(1);
            i++;
        end
        chk(tag, rx_q.size(), n);
    endtask

    int         bad;
    int         bcnt;
    int         pcnt;
    logic [9:0]  fr_a5;
    logic [10:0] fr_7e;
    logic [7:0]  exp3[3];
    logic [7:0]  log6[5];

    initial begin
        // 1: reset and long idle
        rst = 1'b1;
        step(3);
        chk("t1 rst tx",    tx1,   1);
        chk("t1 rst pop",   pop1,  0);
        chk("t1 rst busy",  busy1, 0);
        chk("t1 rst tx2",   tx2,   1);
        chk("t1 rst busy2", busy2, 0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if ((tx1 !== 1'b1) || (pop1 !== 1'b0) || (busy1 !== 1'b0) ||
                (tx2 !== 1'b1) || (pop2 !== 1'b0) || (busy2 !== 1'b0)) bad++;
        end
        chk("t1 idle cycles bad", bad, 0);

        // 2: single byte 0xA5
        clear_mon();
        push_byte(8'hA5);
        step(1);
        chk("t2 pop in latch",  pop1,  1);
        chk("t2 busy in latch", busy1, 1);
        chk("t2 tx in latch",   tx1,   1);
        fr_a5 = 10'h34A;
        for (int j = 0; j < 10; j++) begin
            for (int k = 0; k < 4; k++) begin
                step(1);
                chk($sformatf("t2 bit%0d.%0d", j, k), tx1, fr_a5[j]);
            end
        end
        step(1);
        chk("t2 busy idle exit", busy1, 1);
        step(1);
        chk("t2 busy low", busy1, 0);
        step(4);
        chk("t2 busy cycles", busy_cnt, 42);
        chk("t2 pops", pop_cnt, 1);
        chk("t2 rx count", rx_q.size(), 1);
        chk("t2 rx byte", rx_q[0], 8'hA5);

        // 3: three queued bytes back-to-back
        clear_mon();
        exp3 = '{8'h00, 8'hFF, 8'h55};
        push_byte(8'h00);
        push_byte(8'hFF);
        push_byte(8'h55);
        wait_rx(3, 200, "t3 frames");
        step(10);
        for (int i = 0; i < 3; i++) chk($sformatf("t3 rx%0d", i), rx_q[i], exp3[i]);
        chk("t3 gap count", gap_q.size(), 2);
        chk("t3 gap0", gap_q[0], 2);
        chk("t3 gap1", gap_q[1], 2);
        chk("t3 pops", pop_cnt, 3);
        chk("t3 frame err", frame_err, 0);
        chk("t3 pop empty", pop_empty, 0);

        // 4: reset during data bit 3 of 0x3C, then 0x81
        clear_mon();
        push_byte(8'h3C);
        step(1);
        chk("t4 pop", pop1, 1);
        step(10);
        chk("t4 data bit1", tx1, 0);
        step(8);
        chk("t4 data bit3", tx1,   1);
        chk("t4 busy mid",  busy1, 1);
        rst       = 1'b1;
        mon_clear = 1'b1;
        step(1);
        chk("t4 tx after rst",   tx1,   1);
        chk("t4 busy after rst", busy1, 0);
        chk("t4 pop after rst",  pop1,  0);
        rst       = 1'b0;
        mon_clear = 1'b0;
        step(20);
        chk("t4 no pops", pop_cnt, 0);
        chk("t4 idle busy", busy1, 0);
        chk("t4 no rx", rx_q.size(), 0);
        push_byte(8'h81);
        wait_rx(1, 100, "t4 frame");
        step(6);
        chk("t4 rx byte", rx_q[0], 8'h81);
        chk("t4 frame err", frame_err, 0);
        chk("t4 pops after", pop_cnt, 1);

        // 5: two stop bits, byte 0x7E on dut2
        fr_7e  = 11'h6FC;
        dat2   = 8'h7E;
        empty2 = 1'b0;
        step(1);
        chk("t5 pop",  pop2,  1);
        chk("t5 busy", busy2, 1);
        empty2 = 1'b1;
        bcnt   = 1;
        pcnt   = 1;
        for (int s = 0; s < 44; s++) begin
            step(1);
            chk($sformatf("t5 s%0d", s), tx2, fr_7e[s/4]);
            if (busy2) bcnt++;
            if (pop2) pcnt++;
        end
        for (int s = 0; s < 10; s++) begin
            step(1);
            if (busy2) bcnt++;
            if (pop2) pcnt++;
        end
        chk("t5 busy cycles", bcnt, 46);
        chk("t5 pops", pcnt, 1);
        chk("t5 tx idle", tx2, 1);

        // 6: FIFO filled to full while busy, one push during LATCH
        clear_mon();
        log6 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        push_byte(log6[0]);
        step(1);
        chk("t6 pop in latch", pop1, 1);
        for (int i = 1; i < 5; i++) push_byte(log6[i]);
        wait_rx(5, 400, "t6 frames");
        step(10);
        for (int i = 0; i < 5; i++) chk($sformatf("t6 rx%0d", i), rx_q[i], log6[i]);
        chk("t6 gap count", gap_q.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("t6 gap%0d", i), gap_q[i], 2);
        chk("t6 pops", pop_cnt, 5);
        chk("t6 overflow", ovf, 0);
        chk("t6 frame err", frame_err, 0);
        chk("t6 pop empty", pop_empty, 0);
        chk("t6 busy end", busy1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
